hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage processor. It sits beside the decode stage, compares IF/ID source registers against the ID/EX load destination, and watches taken branches, jumps and the data-memory handshake. Each cycle it drives the write-enable, flush and bubble controls of the PC and the pipeline registers. It also keeps saturating stall and flush counters for performance debug, and latches a sticky error on a data-memory timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum consecutive data-memory wait cycles before an error (≥2).
- CNT_W, 16: width of the performance counters.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in IF/ID.
- id_rt  in  5  rt field of the instruction in IF/ID.
- id_uses_rt  in  1  the IF/ID instruction reads rt (R-type, beq, sw).
- ex_memread  in  1  the ID/EX instruction is a load.
- ex_rt  in  5  destination rt of the ID/EX instruction.
- id_jump  in  1  a jump is decoded in ID.
- mem_branch_taken  in  1  branch resolved taken in the MEM stage.
- dmem_req  in  1  the MEM stage is accessing data memory this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP controls into ID/EX.
- exmem_flush  out  1  clear EX/MEM controls.
- pipe_en  out  1  load enable for ID/EX, EX/MEM and MEM/WB.
- mem_error  out  1  sticky; set on memory timeout.
- stall_cnt  out  CNT_W  stall cycles, saturating.
- flush_cnt  out  CNT_W  flush events, saturating.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. There is also wait_cnt, which is log2(MEM_TIMEOUT)+1 bits wide.
- Derived signals:
  - freeze = dmem_req & ~dmem_ready.
  - load_use = ex_memread & (ex_rt≠0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Outputs are combinational from the state and the inputs. They are evaluated in strict priority order: ERROR, then freeze, then mem_branch_taken, then load_use, then id_jump, then default.
  - ERROR: pc_write=0, ifid_write=0, pipe_en=0, all flush and bubble outputs 0, mem_error=1.
  - freeze (RUN or MEM_WAIT): pc_write=0, ifid_write=0, pipe_en=0, flush and bubble outputs 0. The pipeline holds, so a branch in MEM re-presents after the wait.
  - branch: pc_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1, pipe_en=1. A simultaneous load_use or id_jump is ignored.
  - load_use: pc_write=0, ifid_write=0, idex_bubble=1, pipe_en=1.
  - jump: pc_write=1, ifid_write=1, ifid_flush=1, pipe_en=1.
  - default: pc_write=1, ifid_write=1, pipe_en=1, all others 0.
- FSM transitions:
  - RUN to MEM_WAIT on freeze; wait_cnt becomes 1.
  - MEM_WAIT:
    - dmem_ready=1 goes to RUN, and wait_cnt becomes 0. That cycle is not frozen; normal priorities apply.
    - Else, if wait_cnt==MEM_TIMEOUT-1, go to ERROR.
    - Else wait_cnt increments.
  - ERROR is left only by RST.
- Counters:
  - stall_cnt increments on each cycle with freeze or load_use, outside ERROR.
  - flush_cnt increments on each cycle with a branch or jump flush.
  - Both saturate at 2^CW-1 and never wrap.

## Timing
- RST asserted, asynchronously:
  - state=RUN, wait_cnt=0, counters=0, mem_error=0.
  - Control outputs forced: pc_write=0, ifid_write=0, pipe_en=0, ifid_flush=1, idex_bubble=1, exmem_flush=1.
- Hazard decisions have zero-cycle latency: the controls act in the same cycle the condition appears.
- Load-use inserts exactly one bubble. The next cycle ex_memread=0, so the pipeline advances.
- Memory wait: N wait cycles produce N frozen cycles. The release cycle advances.
- Timeout: with dmem_ready held low, ERROR is entered on the MEM_TIMEOUT-th rising edge after the first freeze cycle.
- RST during MEM_WAIT or ERROR returns to RUN immediately. The first RUN cycle is the first edge after RST deasserts.

## Test plan
- Load-use: ex_memread=1, ex_rt=9, id_rs=9 (instruction 012DB820) → one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1 next cycle. Repeat with ex_rt=0 → no stall.
- id_uses_rt=0, ex_memread=1, ex_rt=id_rt=13, id_rs≠13 → no stall; flip id_uses_rt=1 → stall.
- Branch with simultaneous load_use and id_jump → ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1; flush_cnt increments by 1.
- dmem_req=1, dmem_ready low for 3 cycles → pipe_en=0 for 3 cycles. Release cycle has pipe_en=1; state returns to RUN and stall_cnt=3.
- dmem_ready held low with MEM_TIMEOUT=16 → mem_error=1 after 16 edges, all enables 0. Assert RST → mem_error=0, counters 0.
- Force stall_cnt near 2^CW-1 (CNT_W=4, 20 stalls) → saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Drives PC/pipeline enables, flushes and bubbles; keeps perf counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             id_jump,
  input  logic             mem_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             pipe_en,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic freeze;
  logic load_use;
  logic in_err;
  logic stall_ev;
  logic flush_ev;

  assign freeze = dmem_req & ~dmem_ready;
  assign in_err = (state_q == ERROR);

  assign load_use = ex_memread
                  & (ex_rt != 5'd0)
                  & ((ex_rt == id_rs)
                  | (id_uses_rt & (ex_rt == id_rt)));

  assign stall_ev = ~in_err & (freeze | load_use);

  // A jump loses to load-use, so it only flushes when no stall wins.
  assign flush_ev = ~in_err & ~freeze
                  & (mem_branch_taken
                  | (~load_use & id_jump));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    pipe_en     = 1'b1;
    mem_error   = 1'b0;
    if (RST) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (in_err) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_en    = 1'b0;
      mem_error  = 1'b1;
    end else if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_en    = 1'b0;
    end else if (mem_branch_taken) begin
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    stall_d = stall_q;
    flush_d = flush_q;
    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          wait_d  = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ERROR: ;
      default: state_d = ERROR;
    endcase
    if (stall_ev && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
    if (flush_ev && flush_q != '1)
      flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
